// File: rtl/s2p_arbiter_ctrl.sv
// rtl/s2p_arbiter_ctrl.sv - two-source round-robin arbiter steering one shared serial-to-parallel deserializer
// Grants one source for exactly N serial cycles, captures the assembled word and holds it until accepted.
module s2p_arbiter_ctrl #(
  parameter int N  = 10,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   i_Req,
  input  logic         i_Serial0,
  input  logic         i_Serial1,
  output logic [1:0]   o_Gnt,
  output logic         o_Serial,
  input  logic [N-1:0] i_Parallel,
  output logic [N-1:0] o_Word,
  output logic         o_Src,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic         o_Busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPT, HOLD} state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic [N-1:0]  word_q, word_d;
  logic          src_q, src_d;
  logic          valid_q, valid_d;
  logic          pick;
  logic          start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      word_q  <= '0;
      src_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      word_q  <= word_d;
      src_q   <= src_d;
      valid_q <= valid_d;
    end
  end

  // On a tie the source that was not served last wins; a lone request always wins.
  always_comb begin
    pick  = (i_Req == 2'b11) ? ~last_q : i_Req[1];
    start = (i_Req != 2'b00) && ((state_q == IDLE) || ((state_q == HOLD) && i_Ready));
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    word_d  = word_q;
    src_d   = src_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          gnt_d   = 2'b00;
          last_d  = win_q;
          state_d = CAPT;
        end
      end
      CAPT: begin
        word_d  = i_Parallel;
        src_d   = win_q;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (i_Ready) begin
          valid_d = 1'b0;
          state_d = start ? SHIFT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      win_d = pick;
      gnt_d = pick ? 2'b10 : 2'b01;
      cnt_d = '0;
    end
  end

  always_comb begin
    o_Gnt    = gnt_q;
    o_Serial = (gnt_q[0] & i_Serial0) | (gnt_q[1] & i_Serial1);
    o_Word   = word_q;
    o_Src    = src_q;
    o_Valid  = valid_q;
    o_Busy   = (state_q != IDLE);
  end

endmodule

// File: tb/tb_s2p_arbiter_ctrl.sv
// tb/tb_s2p_arbiter_ctrl.sv - self-checking bench for s2p_arbiter_ctrl with behavioural sources and deserializer
module tb_s2p_arbiter_ctrl;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   i_Req = 2'b00;
  logic         i_Serial0, i_Serial1;
  logic [1:0]   o_Gnt;
  logic         o_Serial;
  logic [N-1:0] i_Parallel;
  logic [N-1:0] o_Word;
  logic         o_Src, o_Valid;
  logic         i_Ready = 1'b0;
  logic         o_Busy;

  s2p_arbiter_ctrl #(.N(N), .CW(4)) dut (
    .clk(clk), .rst(rst), .i_Req(i_Req), .i_Serial0(i_Serial0), .i_Serial1(i_Serial1),
    .o_Gnt(o_Gnt), .o_Serial(o_Serial), .i_Parallel(i_Parallel), .o_Word(o_Word),
    .o_Src(o_Src), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Busy(o_Busy)
  );

  always #5 clk = ~clk;

  logic [N-1:0] w0 = '0, w1 = '0, sr = '0;
  logic [3:0]   bc0 = '0, bc1 = '0;
  int           cyc = 0;
  int           viol = 0;
  int           passed = 0, total = 0;

  always @(posedge clk) begin
    bc0 <= o_Gnt[0] ? bc0 + 4'd1 : 4'd0;
    bc1 <= o_Gnt[1] ? bc1 + 4'd1 : 4'd0;
    sr  <= {o_Serial, sr[N-1:1]};
    cyc <= cyc + 1;
  end

  always_comb begin
    i_Serial0  = w0[bc0];
    i_Serial1  = w1[bc1];
    i_Parallel = sr;
  end

  typedef struct {
    logic [N-1:0] word;
    logic         src;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]   req;
    logic [N-1:0] w0;
    logic [N-1:0] w1;
    int           drop_at;
    int           rdly;
    logic [1:0]   gnt;
    logic [N-1:0] word;
    logic         src;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] word, input logic src);
    exp_t e;
    e.word = word;
    e.src  = src;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string name, input logic [1:0] g);
    int n = 0;
    while (o_Gnt !== g && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(o_Gnt), 32'(g));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (o_Valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(o_Valid), 32'd1);
  endtask

  // Consumer side: every accepted word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst && o_Valid && i_Ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", 32'(o_Word), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_word", 32'(o_Word), 32'(e.word));
        chk("sb_src", 32'(o_Src), 32'(e.src));
      end
    end
    if (o_Gnt == 2'b11 || (o_Gnt != 2'b00 && !o_Busy)) viol++;
  end

  task automatic run_xfer(input vec_t v);
    int g = 0;
    w0 = v.w0;
    w1 = v.w1;
    i_Req = v.req;
    push(v.word, v.src);
    step();
    chk("req_to_gnt", 32'(o_Gnt), 32'(v.gnt));
    while (o_Gnt == v.gnt && g < 40) begin
      g++;
      if (g == v.drop_at) i_Req = 2'b00;
      step();
    end
    i_Req = 2'b00;
    chk("gnt_cycles", 32'(g), 32'(N));
    chk("capt_valid_low", 32'(o_Valid), 32'd0);
    step();
    chk("valid_latency", 32'(o_Valid), 32'd1);
    repeat (v.rdly) step();
    chk("hold_stable", 32'({o_Valid, o_Gnt, o_Word}), 32'({1'b1, 2'b00, v.word}));
    i_Ready = 1'b1;
    step();
    i_Ready = 1'b0;
    chk("valid_drop", 32'(o_Valid), 32'd0);
    chk("idle_after", 32'(o_Busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t1, t2, grants, n;
    logic [1:0] prev;

    tbl[0] = '{2'b01, 10'h2B5, 10'h000, 1, 0, 2'b01, 10'h2B5, 1'b0};
    tbl[1] = '{2'b10, 10'h000, 10'h3A5, 1, 3, 2'b10, 10'h3A5, 1'b1};
    tbl[2] = '{2'b01, 10'h0F0, 10'h3FF, 3, 1, 2'b01, 10'h0F0, 1'b0};
    tbl[3] = '{2'b10, 10'h3FF, 10'h001, 1, 0, 2'b10, 10'h001, 1'b1};
    tbl[4] = '{2'b01, 10'h200, 10'h000, 2, 2, 2'b01, 10'h200, 1'b0};

    // Reset state, with a source driving 1 so o_Serial gating is visible.
    w0 = 10'h3FF;
    rst = 1'b0;
    repeat (3) step();
    chk("rst_gnt", 32'(o_Gnt), 32'd0);
    chk("rst_valid", 32'(o_Valid), 32'd0);
    chk("rst_word", 32'(o_Word), 32'd0);
    chk("rst_src", 32'(o_Src), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_serial", 32'(o_Serial), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_no_req", 32'(o_Busy), 32'd0);

    // Tie right after reset: source 0 first, then source 1 straight from HOLD.
    w0 = 10'h155;
    w1 = 10'h0AA;
    i_Ready = 1'b1;
    push(10'h155, 1'b0);
    push(10'h0AA, 1'b1);
    i_Req = 2'b11;
    step();
    chk("tie_first_gnt", 32'(o_Gnt), 32'd1);
    i_Req = 2'b10;
    wait_valid("tie_valid1");
    t1 = cyc;
    step();
    chk("tie_hold_to_shift", 32'({o_Gnt, o_Valid}), 32'({2'b10, 1'b0}));
    i_Req = 2'b00;
    wait_valid("tie_valid2");
    t2 = cyc;
    chk("tie_spacing", 32'(t2 - t1), 32'd12);
    step();
    i_Ready = 1'b0;
    chk("tie_idle", 32'(o_Busy), 32'd0);

    // Fairness under a continuous double request.
    w0 = 10'h1C3;
    w1 = 10'h23C;
    push(10'h1C3, 1'b0);
    push(10'h23C, 1'b1);
    push(10'h1C3, 1'b0);
    push(10'h23C, 1'b1);
    i_Ready = 1'b1;
    i_Req = 2'b11;
    grants = 0;
    prev = 2'b00;
    n = 0;
    while (n < 200 && !(sb.size() == 0 && !o_Busy && grants > 0)) begin
      step();
      n++;
      if (o_Gnt != 2'b00 && prev == 2'b00) begin
        grants++;
        if (grants == 4) i_Req = 2'b00;
      end
      prev = o_Gnt;
    end
    i_Ready = 1'b0;
    chk("fair_grants", 32'(grants), 32'd4);
    chk("fair_drained", 32'(sb.size()), 32'd0);

    for (int i = 0; i < 5; i++) run_xfer(tbl[i]);

    // Backpressure: word held while the other source waits.
    w0 = 10'h3FF;
    w1 = 10'h2D2;
    push(10'h3FF, 1'b0);
    i_Req = 2'b01;
    wait_gnt("bp_gnt0", 2'b01);
    i_Req = 2'b00;
    wait_valid("bp_valid");
    i_Req = 2'b10;
    push(10'h2D2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", 32'({o_Valid, o_Gnt, o_Word}), 32'({1'b1, 2'b00, 10'h3FF}));
    end
    i_Ready = 1'b1;
    step();
    i_Ready = 1'b0;
    chk("bp_next_gnt", 32'(o_Gnt), 32'd2);
    i_Req = 2'b00;
    wait_valid("bp_valid2");
    i_Ready = 1'b1;
    step();
    i_Ready = 1'b0;

    // Reset during the 5th SHIFT cycle discards the partial word.
    w0 = 10'h2AA;
    i_Req = 2'b01;
    wait_gnt("mid_gnt", 2'b01);
    i_Req = 2'b00;
    repeat (4) step();
    chk("mid_shifting", 32'(o_Gnt), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst", 32'({o_Gnt, o_Busy, o_Valid}), 32'd0);
    step();
    run_xfer('{2'b01, 10'h123, 10'h000, 1, 1, 2'b01, 10'h123, 1'b0});

    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("gnt_invariant", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
